// File: rtl/general_lib.sv
// Shared helpers for the delay-line blocks: address-width calculation and
// the fill/run state encoding used by the variable-delay controller.
package general_lib;

    // Fill/run controller states
    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } fill_state_t;

    // Number of address bits needed to index 'value' entries (ceiling log2)
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port, registered read with
// a read latency of one or two clocks. The read pipeline only advances when
// i_re is high, so a stalled caller sees its read data held in place.
module sdp_ram #(
    parameter int A_WIDTH = 10,
    parameter int D_WIDTH = 32,
    parameter int LATENCY = 2
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [A_WIDTH-1:0] i_waddr,
    input  logic [D_WIDTH-1:0] i_wdata,
    input  logic               i_re,
    input  logic [A_WIDTH-1:0] i_raddr,
    output logic [D_WIDTH-1:0] o_rdata
);

    logic [D_WIDTH-1:0] r_mem [0:(1 << A_WIDTH)-1];
    logic [D_WIDTH-1:0] r_rdStage1;

    // Write port: contents are never cleared, stale data is masked downstream
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // First read stage: the RAM output register
    always_ff @(posedge i_clk) begin
        if (i_re) begin
            r_rdStage1 <= r_mem[i_raddr];
        end
    end

    generate
        if (LATENCY == 1) begin : g_lat1
            assign o_rdata = r_rdStage1;
        end else begin : g_lat2
            logic [D_WIDTH-1:0] r_rdStage2;

            // Optional second read stage for a two-clock read latency
            always_ff @(posedge i_clk) begin
                if (i_re) begin
                    r_rdStage2 <= r_rdStage1;
                end
            end

            assign o_rdata = r_rdStage2;
        end
    endgenerate

endmodule

// File: rtl/bram_var_delay.sv
// Variable-length sample delay line built on a block RAM used as a circular
// buffer. The write pointer advances on every enabled cycle; the read address
// trails it so that, after the RAM latency and the output register, dout lags
// din by exactly the programmed number of enabled cycles. A fill/run
// controller masks the output until the buffer holds enough fresh samples.
module bram_var_delay
    import general_lib::*;
#(
    parameter  int WIDTH         = 32,
    parameter  int MAX_DELAY     = 1024,
    parameter  int LATENCY       = 2,
    parameter  int DEFAULT_DELAY = 16,
    localparam int ADDR_BITS     = log2(MAX_DELAY)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic [WIDTH-1:0]   din,
    input  logic [ADDR_BITS:0] delay,
    input  logic               delay_load,
    output logic [WIDTH-1:0]   dout,
    output logic               dout_valid
);

    localparam int DW = ADDR_BITS + 1;

    // Shortest delay the pipeline can produce: RAM latency plus the output register
    localparam logic [DW-1:0] MIN_DELAY = DW'(LATENCY + 1);
    localparam logic [DW-1:0] MAX_DLY   = DW'(MAX_DELAY);

    localparam int RESET_DELAY_INT = (DEFAULT_DELAY < LATENCY + 1) ? LATENCY + 1 :
                                     (DEFAULT_DELAY > MAX_DELAY)   ? MAX_DELAY     :
                                                                     DEFAULT_DELAY;
    localparam logic [DW-1:0] RESET_DELAY = DW'(RESET_DELAY_INT);

    function automatic logic [DW-1:0] clampDelay(input logic [DW-1:0] req);
        if (req < MIN_DELAY) begin
            return MIN_DELAY;
        end else if (req > MAX_DLY) begin
            return MAX_DLY;
        end
        return req;
    endfunction

    fill_state_t          r_state;
    logic [DW-1:0]        r_fillCnt;
    logic [DW-1:0]        r_delay;
    logic [ADDR_BITS-1:0] r_wrPtr;
    logic [WIDTH-1:0]     r_dout;
    logic                 r_doutValid;

    logic [ADDR_BITS-1:0] w_rdOffset;
    logic [ADDR_BITS-1:0] w_rdAddr;
    logic [WIDTH-1:0]     w_ramRdata;
    logic                 w_validNext;

    // The read already travels LATENCY RAM stages plus the output register,
    // so the read address trails the write pointer by delay - LATENCY.
    // That offset is at least 1 and at most MAX_DELAY - LATENCY, so it never
    // collides with the address being written on the same edge.
    assign w_rdOffset = ADDR_BITS'(r_delay - DW'(LATENCY));
    assign w_rdAddr   = r_wrPtr - w_rdOffset;

    // A load on this cycle invalidates the output immediately
    assign w_validNext = (r_state == RUN) && !delay_load;

    sdp_ram #(
        .A_WIDTH (ADDR_BITS),
        .D_WIDTH (WIDTH),
        .LATENCY (LATENCY)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (ce),
        .i_waddr (r_wrPtr),
        .i_wdata (din),
        .i_re    (ce),
        .i_raddr (w_rdAddr),
        .o_rdata (w_ramRdata)
    );

    // Circular write pointer; keeps running across delay reloads
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
        end else if (ce) begin
            r_wrPtr <= r_wrPtr + 1'b1;
        end
    end

    // Fill/run controller: counts fresh samples after reset or reload, owns dout_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FILL;
            r_fillCnt   <= '0;
            r_delay     <= RESET_DELAY;
            r_doutValid <= 1'b0;
        end else if (ce) begin
            r_doutValid <= w_validNext;
            if (delay_load) begin
                r_state   <= FILL;
                r_fillCnt <= '0;
                r_delay   <= clampDelay(delay);
            end else if (r_state == FILL) begin
                r_fillCnt <= r_fillCnt + 1'b1;
                if (r_fillCnt == (r_delay - DW'(1))) begin
                    r_state <= RUN;
                end
            end
        end
    end

    // Output register: passes RAM data only when it is a genuine delayed sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
        end else if (ce) begin
            r_dout <= w_validNext ? w_ramRdata : '0;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_doutValid;

endmodule

// File: tb/tb_bram_var_delay.sv
// Bench for bram_var_delay: two instances (RAM latency 2 and 1) share the
// same stimulus and are checked against one sample-history model.
module tb_bram_var_delay;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [31:0] din;
    logic [10:0] delay;
    logic        delay_load;
    logic [31:0] dout2;
    logic        valid2;
    logic [31:0] dout1;
    logic        valid1;

    int total;
    int bad;

    // Reference model: samples stored since the last reset/reload, and the
    // effective delay each instance should be using.
    logic [31:0] hist[$];
    int          cnt;
    int          delay2Eff;
    int          delay1Eff;
    int unsigned rampVal;

    typedef struct {
        logic        r;
        logic        c;
        logic        l;
        logic [10:0] d;
        logic [31:0] x;
        logic        expV;
        logic [31:0] expD;
    } vec_t;

    vec_t vecs[12];

    bram_var_delay #(
        .WIDTH         (32),
        .MAX_DELAY     (1024),
        .LATENCY       (2),
        .DEFAULT_DELAY (16)
    ) dut2 (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .din        (din),
        .delay      (delay),
        .delay_load (delay_load),
        .dout       (dout2),
        .dout_valid (valid2)
    );

    bram_var_delay #(
        .WIDTH         (32),
        .MAX_DELAY     (1024),
        .LATENCY       (1),
        .DEFAULT_DELAY (16)
    ) dut1 (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .din        (din),
        .delay      (delay),
        .delay_load (delay_load),
        .dout       (dout1),
        .dout_valid (valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clampRef(input int d, input int lat);
        if (d < lat + 1) return lat + 1;
        if (d > 1024) return 1024;
        return d;
    endfunction

    // Output k ce-cycles after (re)start is valid once more than dly fresh
    // samples exist, and then equals the sample taken dly ce-cycles earlier.
    function automatic void expectedOut(input int dly, output logic v, output logic [31:0] d);
        v = (cnt >= dly + 1);
        d = v ? hist[hist.size() - 1 - dly] : 32'd0;
    endfunction

    task automatic applyStimulus(input logic r, input logic c, input logic l,
                                 input logic [10:0] d, input logic [31:0] x);
        rst        = r;
        ce         = c;
        delay_load = l;
        delay      = d;
        din        = x;
        @(posedge clk);
        #1;
        if (r) begin
            cnt = 0;
            hist.delete();
            delay2Eff = clampRef(16, 2);
            delay1Eff = clampRef(16, 1);
        end else if (c) begin
            if (l) begin
                cnt = 0;
                hist.delete();
                delay2Eff = clampRef(int'(d), 2);
                delay1Eff = clampRef(int'(d), 1);
            end else begin
                hist.push_back(x);
                cnt++;
                if (hist.size() > 1100) void'(hist.pop_front());
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic gotV, input logic [31:0] gotD,
                               input logic expV, input logic [31:0] expD);
        total++;
        if (gotV !== expV || gotD !== expD) begin
            bad++;
            $display("[TB] FAIL %s: got valid=%0b dout=%0h, want valid=%0b dout=%0h",
                     name, gotV, gotD, expV, expD);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic checkModel(input string name);
        logic        ev;
        logic [31:0] ed;
        expectedOut(delay2Eff, ev, ed);
        checkOutput({name, "/lat2"}, valid2, dout2, ev, ed);
        expectedOut(delay1Eff, ev, ed);
        checkOutput({name, "/lat1"}, valid1, dout1, ev, ed);
    endtask

    // Load a delay, then feed a ramp and count invalid ce-cycles before the first valid one
    task automatic measureDelay(input logic [10:0] d, input int budget, output int n2, output int n1);
        n2 = -1;
        n1 = -1;
        applyStimulus(1'b0, 1'b1, 1'b1, d, rampVal);
        rampVal++;
        checkModel("load");
        checkOutput("load_drop/lat2", valid2, dout2, 1'b0, 32'd0);
        for (int k = 1; k <= budget; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 11'd0, rampVal);
            rampVal++;
            checkModel("ramp");
            if (valid2 && n2 < 0) n2 = k - 1;
            if (valid1 && n1 < 0) n1 = k - 1;
        end
    endtask

    // Ramp 1,2,3... straight after reset; report invalid-cycle count and first valid value
    task automatic rampAfterReset(output int n2, output int n1, output int f2, output int f1);
        n2 = -1; n1 = -1; f2 = -1; f1 = -1;
        for (int k = 0; k < 24; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 11'd0, 32'(k + 1));
            checkModel("reset_ramp");
            if (valid2 && n2 < 0) begin n2 = k; f2 = int'(dout2); end
            if (valid1 && n1 < 0) begin n1 = k; f1 = int'(dout1); end
        end
        rampVal = 25;
    endtask

    initial begin
        int n2, n1, f2, f1;
        total = 0;
        bad = 0;
        cnt = 0;
        delay2Eff = 16;
        delay1Eff = 16;
        rampVal = 1;
        rst = 1'b1; ce = 1'b0; din = '0; delay = '0; delay_load = 1'b0;

        // Directed vectors: reset, load of 3, ce stall with ignored load, reset beating load
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 11'd0, 32'd0,  1'b0, 32'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 11'd3, 32'd99, 1'b0, 32'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 11'd0, 32'd10, 1'b0, 32'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 11'd0, 32'd11, 1'b0, 32'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 11'd0, 32'd12, 1'b0, 32'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 11'd0, 32'd13, 1'b1, 32'd10};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 11'd0, 32'd77, 1'b1, 32'd10};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 11'd9, 32'd78, 1'b1, 32'd10};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 11'd0, 32'd14, 1'b1, 32'd11};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 11'd0, 32'd15, 1'b1, 32'd12};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 11'd5, 32'd16, 1'b0, 32'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 11'd0, 32'd1,  1'b0, 32'd0};

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].r, vecs[i].c, vecs[i].l, vecs[i].d, vecs[i].x);
            checkOutput($sformatf("vec%0d/lat2", i), valid2, dout2, vecs[i].expV, vecs[i].expD);
            checkOutput($sformatf("vec%0d/lat1", i), valid1, dout1, vecs[i].expV, vecs[i].expD);
        end

        // Default delay after reset (the load in vector 10 must have lost)
        rampAfterReset(n2, n1, f2, f1);
        checkValue("reset_rise/lat2", n2, 16);
        checkValue("reset_rise/lat1", n1, 16);
        checkValue("reset_first/lat2", f2, 1);
        checkValue("reset_first/lat1", f1, 1);

        // Reload to 5 mid-stream
        measureDelay(11'd5, 12, n2, n1);
        checkValue("load5/lat2", n2, 5);
        checkValue("load5/lat1", n1, 5);

        // Clamping at both ends
        measureDelay(11'd0, 8, n2, n1);
        checkValue("load0/lat2", n2, 3);
        checkValue("load0/lat1", n1, 2);
        measureDelay(11'(4000 % 2048), 1032, n2, n1);
        checkValue("load4000/lat2", n2, 1024);
        checkValue("load4000/lat1", n1, 1024);

        // Random ce at delay 8
        applyStimulus(1'b0, 1'b1, 1'b1, 11'd8, $urandom);
        checkModel("load8");
        for (int k = 0; k < 300; k++) begin
            applyStimulus(1'b0, 1'(($urandom % 2)), 1'b0, 11'd0, $urandom);
            checkModel("ce_rand");
        end

        // Random reloads with random ce, small delays
        for (int k = 0; k < 400; k++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0),
                          11'($urandom_range(0, 40)), $urandom);
            checkModel("reload_rand");
        end

        // Long run at maximum delay across many pointer wraps
        applyStimulus(1'b0, 1'b1, 1'b1, 11'd1024, $urandom);
        checkModel("load1024");
        for (int k = 0; k < 3000; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 11'd0, $urandom);
            checkModel("long_run");
        end

        // Reset mid-run, then recovery
        applyStimulus(1'b1, 1'($urandom % 2), 1'b0, 11'd0, $urandom);
        checkOutput("midrun_reset/lat2", valid2, dout2, 1'b0, 32'd0);
        checkOutput("midrun_reset/lat1", valid1, dout1, 1'b0, 32'd0);
        rampAfterReset(n2, n1, f2, f1);
        checkValue("recover_rise/lat2", n2, 16);
        checkValue("recover_rise/lat1", n1, 16);
        checkValue("recover_first/lat2", f2, 1);
        checkValue("recover_first/lat1", f1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bram_var_delay.md
BRAM_VAR_DELAY -- requirements
Module: bram_var_delay

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data width in bits.
REQ-002 The block SHALL have parameter MAX_DELAY, default 1024, largest supported delay in ce-cycles; power of two.
REQ-003 The block SHALL have parameter LATENCY, default 2, RAM read latency; legal values 1 or 2.
REQ-004 The block SHALL have parameter DEFAULT_DELAY, default 16, delay in force after reset.
REQ-005 The block SHALL have derived localparam ADDR_BITS = log2(MAX_DELAY).
REQ-006 The block SHALL have port clk, input, 1 bit, sole clock; all logic on rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-008 The block SHALL have port ce, input, 1 bit, clock enable (Simulink-style); low freezes all state.
REQ-009 The block SHALL have port din, input, WIDTH bits, sample in.
REQ-010 The block SHALL have port delay, input, ADDR_BITS+1 bits, requested delay in ce-cycles.
REQ-011 The block SHALL have port delay_load, input, 1 bit, one-cycle pulse latching delay; honoured only when ce=1.
REQ-012 The block SHALL have port dout, output, WIDTH bits, delayed sample.
REQ-013 The block SHALL have port dout_valid, output, 1 bit, dout holds a genuine delayed sample.

Function
REQ-014 Every ce=1 cycle SHALL write din to RAM at wr_ptr; wr_ptr SHALL increment modulo MAX_DELAY.
REQ-015 Read address SHALL be wr_ptr - (delay_reg - LATENCY) modulo MAX_DELAY, issued every ce=1 cycle.
REQ-016 In RUN, dout on ce-cycle n SHALL equal din from ce-cycle n - delay_reg.
REQ-017 delay_reg SHALL be clamped on load: values below LATENCY+1 become LATENCY+1; values above MAX_DELAY become MAX_DELAY.
REQ-018 FSM SHALL have two states: FILL and RUN.
REQ-019 The FSM SHALL enter FILL on reset or on an accepted delay_load, with fill_cnt cleared to 0.
REQ-020 In FILL, fill_cnt SHALL increment per ce=1 cycle; the FSM SHALL go to RUN on the ce-cycle fill_cnt reaches delay_reg-1.
REQ-021 dout_valid SHALL be 1 only in RUN; dout SHALL be forced to 0 while dout_valid=0.
REQ-022 delay_load in RUN or FILL SHALL restart FILL; wr_ptr SHALL NOT be reset; no stale pre-load data SHALL be marked valid.
REQ-023 With ce=0, wr_ptr, fill_cnt, FSM state, RAM read pipeline, dout and dout_valid SHALL hold.
REQ-024 delay_load with ce=0 SHALL be ignored.
REQ-025 rst and delay_load in the same cycle SHALL resolve to reset, which wins.
REQ-026 wr_ptr wrap from MAX_DELAY-1 to 0 SHALL cause no glitch on dout or dout_valid.

Reset
REQ-027 On rst=1, wr_ptr SHALL be 0, fill_cnt 0, state FILL, delay_reg DEFAULT_DELAY (clamped), dout 0, dout_valid 0.
REQ-028 Reset SHALL NOT clear RAM contents; masking per REQ-021 covers stale data.
REQ-029 Reset SHALL act regardless of ce.

Structure
REQ-030 log2 function and FSM state encodings SHALL reside in the shared general_lib package/include.
REQ-031 RAM SHALL be one sub-module sdp_ram (simple dual-port, one write port, one read port, parameters A_WIDTH, D_WIDTH, LATENCY, read enable tied to ce).
REQ-032 Counters, clamp, address arithmetic and FSM SHALL be in bram_var_delay itself.

Verification
REQ-033 Reset, ce=1, din=ramp 1,2,3...: dout_valid rises after 16 cycles; first valid dout=1, then dout(n)=din(n-16).
REQ-034 Load delay=5 mid-stream: dout_valid drops next cycle, rises 5 ce-cycles later; dout(n)=din(n-5) thereafter, no value from before the load marked valid.
REQ-035 Load delay=0 and delay=4000 with MAX_DELAY=1024, LATENCY=2: effective delays 3 and 1024 measured on ramp.
REQ-036 ce toggled pseudo-random 50% with delay=8: valid output sequence equals input sequence lagged 8 ce-cycles; held values unchanged during ce=0.
REQ-037 Run 3000 ce-cycles at delay=1024 (multiple wr_ptr wraps): zero mismatches against reference model; assert rst mid-run: outputs 0/0 next cycle, recovery per REQ-033.
REQ-038 Repeat REQ-033 and REQ-036 with LATENCY=1: identical cycle-level results.
